// File: rtl/sipo_capture_pkg.sv
// sipo_capture_pkg
// Shared types and constants for the serial-in/parallel-out capture sequencer.
//   SIPO_WIDTH_DEFAULT : default number of data bits per captured word
//   state_t            : sequencer states (PARITY is only reachable when
//                        SIPO_CAPTURE_PARITY_EN is defined)
package sipo_capture_pkg;

  localparam int SIPO_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/sipo_capture_ctrl_shift_stage.sv
// shift_stage
// One edge-triggered flip-flop stage of the serial-in/parallel-out chain.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears q
//   en    : load d into q on this edge
//   d     : stage input (serial_in or the previous stage's q)
//   q     : stage output
module shift_stage
  import sipo_capture_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sipo_capture_ctrl.sv
// sipo_capture_ctrl
// Sequencer that turns a WIDTH-stage flip-flop chain into a serial receiver:
// a start pulse begins capture, WIDTH bits are shifted in MSB first, and the
// word is presented on a valid/ready handshake.
// Optional feature macro: SIPO_CAPTURE_PARITY_EN adds a trailing even-parity
// bit and drives parity_err; without it parity_err is tied to 0.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset
//   start      : begin capture (sampled only in IDLE)
//   serial_in  : serial data bit
//   bit_valid  : serial_in is valid this cycle
//   out_ready  : consumer accepts data_out
//   busy       : high in every state except IDLE
//   out_valid  : data_out holds a complete word
//   data_out   : parallel word, first captured bit in MSB
//   parity_err : parity mismatch on the held word
//
// state  | meaning
// IDLE   | waiting for start
// SHIFT  | accepting WIDTH data bits
// PARITY | waiting for the trailing parity bit (macro builds only)
// HOLD   | word presented, waiting for out_ready
module sipo_capture_ctrl
  import sipo_capture_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic             w_shift_en;
  logic             w_last_bit;
  logic [WIDTH-1:0] w_chain;
  logic [WIDTH-1:0] w_chain_d;

  assign w_last_bit = (r_count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    busy        = (r_state != IDLE);
    out_valid   = (r_state == HOLD);
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (bit_valid) begin
          w_shift_en = 1'b1;
          if (w_last_bit) begin
`ifdef SIPO_CAPTURE_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = HOLD;
`endif
          end
        end
      end
      PARITY: begin
`ifdef SIPO_CAPTURE_PARITY_EN
        if (bit_valid) w_state_nxt = HOLD;
`else
        w_state_nxt = IDLE;
`endif
      end
      HOLD: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counter saturates naturally: SHIFT is left on the WIDTH-th bit, so it
  // never increments past WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_count <= '0;
    end else if (w_shift_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Stage 0 takes serial_in, every other stage takes its neighbour, so the
  // first bit captured ends up in the MSB after WIDTH shifts.
  assign w_chain_d = {w_chain[WIDTH-2:0], serial_in};

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    shift_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (w_shift_en),
      .d     (w_chain_d[i]),
      .q     (w_chain[i])
    );
  end

  assign data_out = w_chain;

`ifdef SIPO_CAPTURE_PARITY_EN
  logic r_parity_err;

  // Even parity: data bits XOR parity bit must be 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity_err <= 1'b0;
    end else if ((r_state == PARITY) && bit_valid) begin
      r_parity_err <= ^{w_chain, serial_in};
    end else if ((r_state == HOLD) && out_ready) begin
      r_parity_err <= 1'b0;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_capture_ctrl.sv
// tb_sipo_capture_ctrl
// Scoreboard bench: stimulus pushes expected words, a monitor pops and
// compares each time out_valid rises and checks the word stays frozen.
module tb_sipo_capture_ctrl;

  localparam int W = 8;
`ifdef SIPO_CAPTURE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         serial_in;
  logic         bit_valid;
  logic         out_ready;
  logic         busy;
  logic         out_valid;
  logic [W-1:0] data_out;
  logic         parity_err;

  typedef struct packed {
    logic [W-1:0] data;
    logic         perr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sipo_capture_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .serial_in  (serial_in),
    .bit_valid  (bit_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .out_valid  (out_valid),
    .data_out   (data_out),
    .parity_err (parity_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares on each rising out_valid, then checks the word is frozen.
  initial begin : monitor
    logic         prev_v;
    logic [W-1:0] held;
    exp_t         e;
    prev_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_v) begin
        check("sb_expected_word", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("word_data", 32'(data_out), 32'(e.data));
          check("word_parity", 32'(parity_err), 32'(e.perr));
        end
        held = data_out;
      end else if (out_valid) begin
        check("hold_stable", 32'(data_out), 32'(held));
      end
      prev_v = out_valid;
    end
  end

  // Capture one word; returns with the DUT in its first HOLD cycle (#1 after edge).
  task automatic send_word(input logic [W-1:0] w, input logic pbit,
                           input int stall_after, input int stall_len,
                           input logic hold_ready);
    int   sent;
    int   stalls;
    int   cyc;
    exp_t e;
    e.data = w;
    e.perr = (PAR == 1) ? (^w ^ pbit) : 1'b0;
    sb_q.push_back(e);
    out_ready = hold_ready;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    sent   = 0;
    stalls = 0;
    cyc    = 0;
    while (!out_valid && cyc < 200) begin
      if (sent < W + PAR) begin
        if (sent == stall_after && stalls < stall_len) begin
          bit_valid = 1'b0;
          serial_in = ~serial_in;
          stalls++;
        end else begin
          bit_valid = 1'b1;
          serial_in = (sent < W) ? w[W-1-sent] : pbit;
          sent++;
        end
      end else begin
        bit_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (!out_valid) check("busy_during_capture", 32'(busy), 1);
    end
    bit_valid = 1'b0;
    check("latency", 32'(cyc), 32'(W + PAR + stall_len));
  endtask

  task automatic release_check();
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_one_cycle", 32'(out_valid), 0);
    check("idle_after_ready", 32'(busy), 0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    serial_in = 1'b0;
    bit_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    reset = 1'b0;

    // Basic capture, ready already high: out_valid for exactly one cycle.
    send_word(8'hA5, 1'b0, -1, 0, 1'b1);
    release_check();

    // Stall of 3 cycles after bit 4.
    send_word(8'hA5, 1'b0, 4, 3, 1'b1);
    release_check();

    // Backpressure: HOLD with serial noise and start pulses.
    send_word(8'hA5, 1'b0, -1, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      serial_in = k[0];
      bit_valid = 1'b1;
      start     = (k == 1 || k == 3);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_data", 32'(data_out), 32'hA5);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    bit_valid = 1'b0;
    check("bp_release_valid", 32'(out_valid), 0);
    check("bp_release_busy", 32'(busy), 0);
    @(posedge clk); #1;
    check("start_not_queued", 32'(busy), 0);

    // Reset after 5 bits discards the word.
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bit_valid = 1'b1;
      serial_in = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    bit_valid = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_data", 32'(data_out), 0);
    @(posedge clk); #1;
    check("midrst_no_valid", 32'(out_valid), 0);
    send_word(8'h3C, 1'b0, -1, 0, 1'b1);
    release_check();

    // Edge bit patterns.
    send_word(8'h01, 1'b1, -1, 0, 1'b1);
    release_check();
    send_word(8'h80, 1'b1, 0, 1, 1'b1);
    release_check();

`ifdef SIPO_CAPTURE_PARITY_EN
    send_word(8'hA5, 1'b0, -1, 0, 1'b1);
    release_check();
    send_word(8'hA5, 1'b1, -1, 0, 1'b0);
    @(posedge clk); #1;
    check("perr_held", 32'(parity_err), 1);
    check("perr_valid", 32'(out_valid), 1);
    release_check();
    check("perr_cleared", 32'(parity_err), 0);
`else
    check("perr_tied", 32'(parity_err), 0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
